// File: rtl/sda_kernel_ctrl_axi_master_if.sv
// Register request port and single-beat AXI-Lite master bus bundled for sda_kernel_ctrl_axi_master.
// The master modport is the DUT view; the slave modport is the requester/responder view.
interface sda_kernel_ctrl_axi_master_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  reg_req;
  logic                  reg_ack;
  logic                  reg_write_en;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]           reg_wdata;
  logic [3:0]            reg_wstrb;
  logic [31:0]           reg_rdata;
  logic                  reg_err;

  logic [ADDR_WIDTH-1:0] m_axi_AWADDR;
  logic                  m_axi_AWVALID;
  logic                  m_axi_AWREADY;
  logic [31:0]           m_axi_WDATA;
  logic [3:0]            m_axi_WSTRB;
  logic                  m_axi_WVALID;
  logic                  m_axi_WREADY;
  logic [1:0]            m_axi_BRESP;
  logic                  m_axi_BVALID;
  logic                  m_axi_BREADY;
  logic [ADDR_WIDTH-1:0] m_axi_ARADDR;
  logic                  m_axi_ARVALID;
  logic                  m_axi_ARREADY;
  logic [31:0]           m_axi_RDATA;
  logic [1:0]            m_axi_RRESP;
  logic                  m_axi_RVALID;
  logic                  m_axi_RREADY;

  modport master (
    input  reg_req, reg_write_en, reg_addr, reg_wdata, reg_wstrb,
    output reg_ack, reg_rdata, reg_err,
    output m_axi_AWADDR, m_axi_AWVALID, input m_axi_AWREADY,
    output m_axi_WDATA, m_axi_WSTRB, m_axi_WVALID, input m_axi_WREADY,
    input  m_axi_BRESP, m_axi_BVALID, output m_axi_BREADY,
    output m_axi_ARADDR, m_axi_ARVALID, input m_axi_ARREADY,
    input  m_axi_RDATA, m_axi_RRESP, m_axi_RVALID, output m_axi_RREADY
  );

  modport slave (
    output reg_req, reg_write_en, reg_addr, reg_wdata, reg_wstrb,
    input  reg_ack, reg_rdata, reg_err,
    input  m_axi_AWADDR, m_axi_AWVALID, output m_axi_AWREADY,
    input  m_axi_WDATA, m_axi_WSTRB, m_axi_WVALID, output m_axi_WREADY,
    output m_axi_BRESP, m_axi_BVALID, input m_axi_BREADY,
    input  m_axi_ARADDR, m_axi_ARVALID, output m_axi_ARREADY,
    output m_axi_RDATA, m_axi_RRESP, m_axi_RVALID, input m_axi_RREADY
  );
endinterface

// File: rtl/sda_kernel_ctrl_axi_master.sv
// Four-phase req/ack register port to single-beat AXI-Lite master, one transaction outstanding.
// Optional stall detector enabled by SDA_KERNEL_CTRL_AXI_MASTER_STALL_DETECT_EN.
module sda_kernel_ctrl_axi_master #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
`ifdef SDA_KERNEL_CTRL_AXI_MASTER_STALL_DETECT_EN
  output logic stall,
`endif
  sda_kernel_ctrl_axi_master_if.master bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {StIdle, StWr, StWb, StRa, StRd, StAck, StRel} state_e;

  state_e                state_q, state_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  ack_q, ack_d, err_q, err_d;
  logic [31:0]           rdata_q, rdata_d, wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack_d     = ack_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.reg_req) begin
          addr_d  = bus.reg_addr;
          wdata_d = bus.reg_wdata;
          wstrb_d = bus.reg_wstrb;
          err_d   = 1'b0;
          if (bus.reg_write_en) begin
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRa;
            arvalid_d = 1'b1;
          end
        end
      end
      StWr: begin
        // A channel counts as done once its VALID has already dropped or handshakes now.
        if (awvalid_q && bus.m_axi_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && bus.m_axi_WREADY)   wvalid_d  = 1'b0;
        if ((!awvalid_q || bus.m_axi_AWREADY) && (!wvalid_q || bus.m_axi_WREADY)) begin
          state_d  = StWb;
          bready_d = 1'b1;
        end
      end
      StWb: begin
        if (bus.m_axi_BVALID) begin
          err_d    = (bus.m_axi_BRESP != 2'b00);
          bready_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = StAck;
        end
      end
      StRa: begin
        if (bus.m_axi_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRd;
        end
      end
      StRd: begin
        if (bus.m_axi_RVALID) begin
          rdata_d  = bus.m_axi_RDATA;
          err_d    = (bus.m_axi_RRESP != 2'b00);
          rready_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = StAck;
        end
      end
      StAck: begin
        if (!bus.reg_req) begin
          ack_d   = 1'b0;
          state_d = StRel;
        end
      end
      StRel:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef SDA_KERNEL_CTRL_AXI_MASTER_STALL_DETECT_EN
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        stall_q, stall_d, busy;
  logic        err_fin;

  always_comb begin
    busy    = (state_q == StWr) || (state_q == StWb) || (state_q == StRa) || (state_q == StRd);
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    cnt_d   = cnt_q;
    if (state_q == StIdle && state_d != StIdle) cnt_d = 16'd0;
    else if (busy)                              cnt_d = cnt_inc;
    stall_d = stall_q | (busy && ({16'd0, cnt_inc} >= TIMEOUT_CYCLES));
    err_fin = err_d;
    // Entering ACK: fold the stall into the response error and release the flag.
    if (state_q != StAck && state_d == StAck) begin
      err_fin = err_d | stall_d;
      stall_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q   <= 16'd0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  logic err_fin;
  assign err_fin = err_d;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= StIdle;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      err_q     <= err_fin;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
    end
  end

  assign bus.reg_ack       = ack_q;
  assign bus.reg_err       = err_q;
  assign bus.reg_rdata     = rdata_q;
  assign bus.m_axi_AWADDR  = addr_q;
  assign bus.m_axi_AWVALID = awvalid_q;
  assign bus.m_axi_WDATA   = wdata_q;
  assign bus.m_axi_WSTRB   = wstrb_q;
  assign bus.m_axi_WVALID  = wvalid_q;
  assign bus.m_axi_BREADY  = bready_q;
  assign bus.m_axi_ARADDR  = addr_q;
  assign bus.m_axi_ARVALID = arvalid_q;
  assign bus.m_axi_RREADY  = rready_q;

endmodule

// File: doc/sda_kernel_ctrl_axi_master.md
Name: sda_kernel_ctrl_axi_master

Overview:
- AXI-Lite master that converts the simple register request interface (req/ack, write_en, addr, wdata, rdata) into single-beat AXI-Lite control-bus transactions.
- It is the initiator-side counterpart of the kernel control slave path.
- It drives s_axi_control_* on a kernel wrapper from a host-model sequencer or an on-chip test/control engine, for example to write the run bit at offset 0 and poll done status.
- One transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 6, width of the AXI-Lite address and of reg_addr.
- TIMEOUT_CYCLES, 1024, stall threshold; used only with the optional feature. Must be ≥2.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- reg_req  in  1  request, four-phase level.
- reg_ack  out  1  acknowledge, four-phase level.
- reg_write_en  in  1  1=write, 0=read.
- reg_addr  in  ADDR_WIDTH  byte address.
- reg_wdata  in  32  write data.
- reg_wstrb  in  4  write byte strobes.
- reg_rdata  out  32  read data; valid while reg_ack=1 after a read.
- reg_err  out  1  response error; valid while reg_ack=1.
- m_axi_AWADDR/AWVALID/AWREADY  out/out/in  ADDR_WIDTH/1/1  write address channel.
- m_axi_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel.
- m_axi_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel.
- m_axi_ARADDR/ARVALID/ARREADY  out/out/in  ADDR_WIDTH/1/1  read address channel.
- m_axi_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel.
- stall  out  1  present only with the optional feature; see below.

Behaviour:
- Reset: async assert, sync release. While reset is asserted:
  - State is IDLE.
  - All VALID and READY outputs, reg_ack, reg_err and stall are 0.
  - reg_rdata=0; AWADDR/ARADDR/WDATA/WSTRB=0.
- States: IDLE, WR (AW/W outstanding), WB (wait B), RA (AR outstanding), RD (wait R), ACK, REL.
- IDLE:
  - On reg_req=1, capture addr, wdata, wstrb and write_en into registers.
  - Write: go to WR, with AWVALID=WVALID=1 from the next cycle.
  - Read: go to RA, with ARVALID=1 from the next cycle.
- WR:
  - AW and W complete independently. Each VALID drops the cycle after its own handshake (VALID&READY); the other VALID is held.
  - When both have completed, go to WB with BREADY=1.
  - If both handshakes occur in the same cycle, go straight to WB.
  - A VALID is never withdrawn before its handshake. Payload is stable while VALID=1.
- WB: on BVALID&BREADY, reg_err<=(BRESP!=0), BREADY<=0, go to ACK.
- RA: on ARVALID&ARREADY, ARVALID<=0, RREADY<=1, go to RD.
- RD: on RVALID&RREADY, reg_rdata<=RDATA, reg_err<=(RRESP!=0), RREADY<=0, go to ACK.
- ACK: reg_ack=1, held until reg_req=0. Then reg_ack<=0 and go to REL.
- REL: one cycle, then IDLE. reg_req must not re-rise before IDLE; a re-rise during REL is ignored until IDLE.
- After a write, reg_rdata keeps its previous value.
- Minimum latency with slave READYs tied high and zero-wait responses:
  - Write: req sampled at cycle N, AW/W handshake N+1, B handshake N+2, reg_ack=1 at N+3.
  - Read: same timing, with reg_ack=1 at N+3.
- reg_addr, wdata and write_en changes after capture have no effect.
- BVALID or RVALID arriving outside WB/RD is protocol misuse by the slave. It is not acknowledged (READY=0) and causes no state change.
- Reset mid-transaction: all VALIDs and READYs drop immediately (async), state=IDLE, the transaction is lost.

Optional Feature:
- Macro: SDA_KERNEL_CTRL_AXI_MASTER_STALL_DETECT_EN.
- Defined:
  - A 16-bit counter clears on leaving IDLE and increments in WR/WB/RA/RD.
  - stall=1 once the count reaches TIMEOUT_CYCLES. It stays 1 until the state reaches ACK, then goes to 0.
  - The counter saturates.
  - The transaction is never abandoned, so AXI rules are preserved.
  - When stall was set during the transaction, reg_err is forced to 1 in ACK.
- Undefined: no stall port, no counter, reg_err reflects only RESP.

Test Plan:
- Write addr=0x00, wdata=0x1, wstrb=0xF, slave READYs high, BRESP=0 -> AWADDR=0x00, WDATA=0x1 on the same cycle; reg_ack rises 3 cycles after req; reg_err=0.
- Read addr=0x00, slave returns RDATA=0x0000_0002 with RRESP=0 after 5 wait cycles -> reg_rdata=0x2, reg_err=0, ARVALID high exactly until the AR handshake.
- Write with AWREADY delayed 4 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 5 cycles, WDATA stable, a single B handshake, one ack.
- Read with RRESP=2'b10 -> reg_err=1 in ACK; reg_req held high 3 extra cycles -> reg_ack held, no second AR issued.
- Assert ap_rst_n=0 while AWVALID=1 -> all outputs 0 in the same cycle; next request after release completes normally.
- With the macro defined and TIMEOUT_CYCLES=8, BVALID withheld 20 cycles -> stall=1 from the 8th outstanding cycle; then B with OKAY -> ack with reg_err=1, stall=0.
